// File: rtl/switch_led_controller.sv
// switch_led_controller
// Drives the four board LEDs from four slide switches and a mode button.
// All five raw inputs are synchronised (2-FF) and debounced. A mode FSM then
// selects one of three LED behaviours:
//   PASS   (00) - LEDs follow the debounced switches
//   TOGGLE (01) - each switch press flips its LED
//   CHASE  (10) - a single lit LED rotates every CHASE_CNT cycles
// Optional feature macro: CHASE_DIR_EN - when defined, stable switch 1 = 1
// reverses the CHASE rotation (LED4->3->2->1->4).
// Ports:
//   iClk               system clock, rising edge
//   iRst               asynchronous active-high reset
//   iSwitch_1..4       raw switches, asynchronous to iClk
//   iMode_Btn          raw mode button, asynchronous to iClk
//   oLED_1..4          registered LED outputs
//   oMode[1:0]         current mode (00 PASS, 01 TOGGLE, 10 CHASE)
module switch_led_controller #(
    parameter int DEBOUNCE_CNT = 250000,
    parameter int CHASE_CNT    = 6250000
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iSwitch_1,
    input  logic       iSwitch_2,
    input  logic       iSwitch_3,
    input  logic       iSwitch_4,
    input  logic       iMode_Btn,
    output logic       oLED_1,
    output logic       oLED_2,
    output logic       oLED_3,
    output logic       oLED_4,
    output logic [1:0] oMode
);

    localparam int DB_W = $clog2(DEBOUNCE_CNT);
    localparam int CH_W = $clog2(CHASE_CNT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHASE_CNT - 1);
    localparam logic [CH_W-1:0] CH_ZERO = {CH_W{1'b0}};
    localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_CHASE  = 2'b10
    } mode_e;

    // Bit 4 is the mode button, bits 3:0 are switches 4..1.
    logic [4:0]            raw_s;
    logic [4:0]            sync1_q;
    logic [4:0]            sync2_q;
    logic [4:0]            stable_q;
    logic [4:0]            stable_d;
    logic [4:0]            stable_dly_q;
    logic [4:0][DB_W-1:0]  db_cnt_q;
    logic [4:0][DB_W-1:0]  db_cnt_d;
    logic [4:0]            rise_s;
    logic [3:0]            sw_rise_s;
    logic                  mode_rise_s;

    mode_e                 state_q;
    mode_e                 state_d;
    logic [3:0]            toggle_q;
    logic [3:0]            toggle_d;
    logic [1:0]            pos_q;
    logic [1:0]            pos_d;
    logic [CH_W-1:0]       tick_q;
    logic [CH_W-1:0]       tick_d;
    logic [3:0]            led_q;
    logic [3:0]            led_d;

    assign raw_s       = {iMode_Btn, iSwitch_4, iSwitch_3, iSwitch_2, iSwitch_1};
    assign rise_s      = stable_q & ~stable_dly_q;
    assign sw_rise_s   = rise_s[3:0];
    assign mode_rise_s = rise_s[4];

    // Debounce: accept s2 once it has differed from stable for DEBOUNCE_CNT cycles in a row.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 5; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = DB_ZERO;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = DB_ZERO;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
        end
    end

    // Mode FSM next state: advances only on a debounced rising edge of the button.
    always_comb begin
        state_d = state_q;
        if (mode_rise_s) begin
            case (state_q)
                MODE_PASS:   state_d = MODE_TOGGLE;
                MODE_TOGGLE: state_d = MODE_CHASE;
                MODE_CHASE:  state_d = MODE_PASS;
                default:     state_d = MODE_PASS;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Per-mode datapath: a mode change re-initialises everything and swallows switch rises.
    always_comb begin
        toggle_d = toggle_q;
        pos_d    = pos_q;
        tick_d   = tick_q;
        if (mode_rise_s) begin
            toggle_d = 4'b0000;
            pos_d    = 2'd0;
            tick_d   = CH_ZERO;
        end else begin
            case (state_q)
                MODE_PASS: begin
                    toggle_d = toggle_q;
                end
                MODE_TOGGLE: begin
                    toggle_d = toggle_q ^ sw_rise_s;
                end
                MODE_CHASE: begin
                    if (tick_q == CH_LAST) begin
                        tick_d = CH_ZERO;
`ifdef CHASE_DIR_EN
                        // Direction is taken from switch 1 at the moment of each step.
                        pos_d  = stable_q[0] ? (pos_q - 2'd1) : (pos_q + 2'd1);
`else
                        pos_d  = pos_q + 2'd1;
`endif
                    end else begin
                        tick_d = tick_q + CH_ONE;
                    end
                end
                default: begin
                    toggle_d = 4'b0000;
                end
            endcase
        end
    end

    // LED next value: uses the current (pre-change) state, so a new mode shows one edge later.
    always_comb begin
        led_d = 4'b0000;
        case (state_q)
            MODE_PASS:   led_d = stable_q[3:0];
            MODE_TOGGLE: led_d = toggle_q;
            MODE_CHASE:  led_d = 4'b0001 << pos_q;
            default:     led_d = 4'b0000;
        endcase
    end

    // State registers with asynchronous reset back to PASS, LEDs off.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync1_q      <= 5'b00000;
            sync2_q      <= 5'b00000;
            stable_q     <= 5'b00000;
            stable_dly_q <= 5'b00000;
            db_cnt_q     <= {(5*DB_W){1'b0}};
            state_q      <= MODE_PASS;
            toggle_q     <= 4'b0000;
            pos_q        <= 2'd0;
            tick_q       <= CH_ZERO;
            led_q        <= 4'b0000;
        end else begin
            sync1_q      <= raw_s;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            toggle_q     <= toggle_d;
            pos_q        <= pos_d;
            tick_q       <= tick_d;
            led_q        <= led_d;
        end
    end

    assign oLED_1 = led_q[0];
    assign oLED_2 = led_q[1];
    assign oLED_3 = led_q[2];
    assign oLED_4 = led_q[3];
    assign oMode  = state_q;

endmodule

// File: tb/tb_switch_led_controller.sv
// Testbench for switch_led_controller (DEBOUNCE_CNT=4, CHASE_CNT=8, 10 ns clock).
// Inputs are driven 1 ns after a rising edge; that edge is "edge 0" and the
// first capture happens at edge 1. Outputs are sampled 1 ns after edges.
module tb_switch_led_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = 4'b0000;
    logic       btn = 1'b0;
    logic       led1, led2, led3, led4;
    logic [1:0] mode;
    logic [3:0] leds;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] led;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    assign leds = {led4, led3, led2, led1};

    switch_led_controller #(.DEBOUNCE_CNT(4), .CHASE_CNT(8)) dut (
        .iClk      (clk),
        .iRst      (rst),
        .iSwitch_1 (sw[0]),
        .iSwitch_2 (sw[1]),
        .iSwitch_3 (sw[2]),
        .iSwitch_4 (sw[3]),
        .iMode_Btn (btn),
        .oLED_1    (led1),
        .oLED_2    (led2),
        .oLED_3    (led3),
        .oLED_4    (led4),
        .oMode     (mode)
    );

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean button press: checks oMode changes at edge 7, then releases.
    task automatic press(input string nm, input logic [1:0] exp_mode);
        btn = 1'b1;
        step(7);
        check(nm, {2'b00, mode}, {2'b00, exp_mode});
        btn = 1'b0;
        step(8);
    endtask

    logic [3:0] chase_exp [4];
    logic [3:0] full_exp;
    logic [3:0] cur_sw;
    logic [3:0] new_sw;
    logic [3:0] m_tog;
    int         m_mode;

    initial begin
        tbl[0] = '{sw: 4'b0000, led: 4'b0000};
        tbl[1] = '{sw: 4'b1010, led: 4'b1010};
        tbl[2] = '{sw: 4'b0101, led: 4'b0101};
        tbl[3] = '{sw: 4'b1111, led: 4'b1111};
        tbl[4] = '{sw: 4'b1001, led: 4'b1001};
        tbl[5] = '{sw: 4'b0110, led: 4'b0110};
`ifdef CHASE_DIR_EN
        chase_exp[0] = 4'b1000; chase_exp[1] = 4'b0100;
        chase_exp[2] = 4'b0010; chase_exp[3] = 4'b0001;
        full_exp     = 4'b0101;
`else
        chase_exp[0] = 4'b0010; chase_exp[1] = 4'b0100;
        chase_exp[2] = 4'b1000; chase_exp[3] = 4'b0001;
        full_exp     = 4'b0100;
`endif

        // Reset state
        step(3);
        check("reset_mode", {2'b00, mode}, 4'b0000);
        check("reset_leds", leds, 4'b0000);
        rst = 1'b0;
        step(2);

        // PASS latency: LED1 rises exactly at edge 7
        sw[0] = 1'b1;
        step(6);
        check("pass_lat_e6", leds, 4'b0000);
        step(1);
        check("pass_lat_e7", leds, 4'b0001);
        sw[0] = 1'b0;
        step(10);
        check("pass_release", leds, 4'b0000);

        // Bounce rejection then clean acceptance
        sw[1] = 1'b1;
        step(3);
        sw[1] = 1'b0;
        step(10);
        check("bounce_reject", leds, 4'b0000);
        sw[1] = 1'b1;
        step(6);
        check("bounce_e6", leds, 4'b0000);
        step(1);
        check("bounce_e7", leds, 4'b0010);
        sw[1] = 1'b0;
        step(10);

        // Enter TOGGLE
        btn = 1'b1;
        step(6);
        check("mode_e6", {2'b00, mode}, 4'b0000);
        step(1);
        check("mode_toggle", {2'b00, mode}, 4'b0001);
        step(1);
        check("toggle_entry_leds", leds, 4'b0000);
        btn = 1'b0;
        step(10);

        // Switch 3 press/release twice
        sw[2] = 1'b1;
        step(7);
        check("toggle_e7", leds, 4'b0000);
        step(1);
        check("toggle_on", leds, 4'b0100);
        sw[2] = 1'b0;
        step(10);
        check("toggle_hold", leds, 4'b0100);
        sw[2] = 1'b1;
        step(10);
        check("toggle_off", leds, 4'b0000);
        sw[2] = 1'b0;
        step(10);

        // Simultaneous mode and switch press: mode wins, entering CHASE
        btn   = 1'b1;
        sw[2] = 1'b1;
`ifdef CHASE_DIR_EN
        sw[0] = 1'b1;
`endif
        step(7);
        check("simul_mode", {2'b00, mode}, 4'b0010);
        check("simul_no_toggle", leds, 4'b0000);
        step(1);
        check("chase_entry", leds, 4'b0001);
        btn = 1'b0;

        // CHASE steps every 8 cycles including wrap
        for (int k = 0; k < 4; k++) begin
            step(8);
            check($sformatf("chase_step%0d", k + 1), leds, chase_exp[k]);
        end

        // Third press: back to PASS, LEDs show stable switches one edge later
        btn = 1'b1;
        step(7);
        check("full_cycle_mode", {2'b00, mode}, 4'b0000);
        step(1);
        check("full_cycle_leds", leds, full_exp);
        btn = 1'b0;
        step(8);

        // Back into CHASE and wait for LED3, then reset mid-operation
        press("to_toggle", 2'b01);
        check("toggle_again_leds", leds, 4'b0000);
        press("to_chase", 2'b10);
        step(9);
        check("chase_led3", leds, 4'b0100);
        rst = 1'b1;
        #1;
        check("midreset_mode", {2'b00, mode}, 4'b0000);
        check("midreset_leds", leds, 4'b0000);
        step(2);
        check("reset_hold_leds", leds, 4'b0000);
        rst = 1'b0;
        step(2);
        check("post_reset_mode", {2'b00, mode}, 4'b0000);

        // Table-driven PASS vectors
        for (int i = 0; i < 6; i++) begin
            sw = tbl[i].sw;
            step(10);
            check($sformatf("table%0d", i), leds, tbl[i].led);
        end

        // Randomised events against a settle-point reference model
        cur_sw = sw;
        m_mode = 0;
        m_tog  = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                btn = 1'b1;
                step(10);
                btn = 1'b0;
                step(10);
                m_mode = (m_mode + 1) % 3;
                if (m_mode == 1) m_tog = 4'b0000;
            end else begin
                new_sw = 4'($urandom_range(0, 15));
                if (m_mode == 1) m_tog = m_tog ^ (new_sw & ~cur_sw);
                cur_sw = new_sw;
                sw     = new_sw;
                step(12);
            end
            check($sformatf("rand%0d_mode", n), {2'b00, mode}, 4'(m_mode));
            if (m_mode == 0) begin
                check($sformatf("rand%0d_pass", n), leds, cur_sw);
            end else if (m_mode == 1) begin
                check($sformatf("rand%0d_toggle", n), leds, m_tog);
            end else begin
                check($sformatf("rand%0d_chase", n), 4'($countones(leds)), 4'd1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
